// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run / run-N controller producing a one-cycle CPU clock-enable strobe,
// with a PC breakpoint that stops runs and a free-running pulse counter.
module cpu_step_ctrl #(
    parameter int DIV_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             step_btn,
    input  logic             run_btn,
    input  logic             runn_btn,
    input  logic [CNT_W-1:0] run_count,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             cpu_clk_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] remaining,
    output logic [31:0]      steps,
    output logic             bp_hit
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2,
        S_RUNN = 2'd3
    } state_t;

    localparam int B_STEP = 0;
    localparam int B_RUN  = 1;
    localparam int B_RUNN = 2;

    logic [2:0]       btn_vec;
    logic [2:0]       btn_q_reg;
    logic [2:0]       btn_edge;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [31:0]      steps_reg;
    logic             bp_hit_reg, bp_hit_next;
    logic             first_tick_reg, first_tick_next;
    logic             cpu_clk_en_reg, cpu_clk_en_next;
    logic             tick;
    logic             bp_match;

    assign btn_vec = {runn_btn, run_btn, step_btn};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn_edge
            assign btn_edge[gi] = btn_vec[gi] & ~btn_q_reg[gi];
        end
    endgenerate

    // >= rather than == so that lowering rate_div mid-run still produces a tick promptly.
    assign tick     = (div_cnt_reg >= rate_div);
    assign bp_match = bp_en && (pc == bp_addr) && !first_tick_reg;

    always_comb begin
        state_next      = state_reg;
        div_cnt_next    = div_cnt_reg;
        remaining_next  = remaining_reg;
        bp_hit_next     = bp_hit_reg;
        first_tick_next = first_tick_reg;
        cpu_clk_en_next = 1'b0;

        unique case (state_reg)
            S_HALT: begin
                if (btn_edge[B_RUN]) begin
                    state_next      = S_RUN;
                    div_cnt_next    = '0;
                    first_tick_next = 1'b1;
                    bp_hit_next     = 1'b0;
                end else if (btn_edge[B_RUNN]) begin
                    if (run_count != '0) begin
                        state_next      = S_RUNN;
                        remaining_next  = run_count;
                        div_cnt_next    = '0;
                        first_tick_next = 1'b1;
                        bp_hit_next     = 1'b0;
                    end
                end else if (btn_edge[B_STEP]) begin
                    state_next      = S_STEP;
                    cpu_clk_en_next = 1'b1;
                    bp_hit_next     = 1'b0;
                end
            end

            S_STEP: begin
                state_next = S_HALT;
            end

            S_RUN, S_RUNN: begin
                if (btn_edge[B_RUN]) begin
                    state_next     = S_HALT;
                    remaining_next = '0;
                    div_cnt_next   = '0;
                end else if (tick) begin
                    div_cnt_next    = '0;
                    first_tick_next = 1'b0;
                    if (bp_match) begin
                        state_next     = S_HALT;
                        bp_hit_next    = 1'b1;
                        remaining_next = '0;
                    end else begin
                        cpu_clk_en_next = 1'b1;
                        if (state_reg == S_RUNN) begin
                            remaining_next = remaining_reg - CNT_W'(1);
                            if (remaining_reg == CNT_W'(1)) begin
                                state_next = S_HALT;
                            end
                        end
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_W'(1);
                end
            end

            default: state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            btn_q_reg      <= '0;
            state_reg      <= S_HALT;
            div_cnt_reg    <= '0;
            remaining_reg  <= '0;
            steps_reg      <= '0;
            bp_hit_reg     <= 1'b0;
            first_tick_reg <= 1'b0;
            cpu_clk_en_reg <= 1'b0;
        end else begin
            btn_q_reg      <= btn_vec;
            state_reg      <= state_next;
            div_cnt_reg    <= div_cnt_next;
            remaining_reg  <= remaining_next;
            bp_hit_reg     <= bp_hit_next;
            first_tick_reg <= first_tick_next;
            cpu_clk_en_reg <= cpu_clk_en_next;
            // Counted alongside the strobe so steps already includes the pulse being shown.
            if (cpu_clk_en_next) begin
                steps_reg <= steps_reg + 32'd1;
            end
        end
    end

    assign cpu_clk_en = cpu_clk_en_reg;
    assign state      = state_reg;
    assign remaining  = remaining_reg;
    assign steps      = steps_reg;
    assign bp_hit     = bp_hit_reg;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: step, run, run-N, breakpoint, priority and reset scenarios
// with hand-computed expectations checked by immediate assertions.
module tb_cpu_step_ctrl;

    localparam int DIV_W = 24;
    localparam int CNT_W = 16;

    logic             clk_50M   = 1'b0;
    logic             rst_n     = 1'b0;
    logic             step_btn  = 1'b0;
    logic             run_btn   = 1'b0;
    logic             runn_btn  = 1'b0;
    logic [CNT_W-1:0] run_count = '0;
    logic [DIV_W-1:0] rate_div  = '0;
    logic             bp_en     = 1'b0;
    logic [31:0]      bp_addr   = '0;
    logic [31:0]      pc        = '0;
    logic             cpu_clk_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] remaining;
    logic [31:0]      steps;
    logic             bp_hit;

    int checks = 0;
    int errors = 0;
    bit track_pc = 1'b0;
    int pulses;
    int halt_k;

    cpu_step_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .step_btn   (step_btn),
        .run_btn    (run_btn),
        .runn_btn   (runn_btn),
        .run_count  (run_count),
        .rate_div   (rate_div),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_clk_en (cpu_clk_en),
        .state      (state),
        .remaining  (remaining),
        .steps      (steps),
        .bp_hit     (bp_hit)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance n clock edges; samples land 1 time unit after each edge. The modelled CPU
    // advances its PC on the edge that ends a cycle in which the strobe was high.
    task automatic cyc(input int n);
        logic was_en;
        for (int i = 0; i < n; i++) begin
            was_en = cpu_clk_en;
            @(posedge clk_50M);
            #1;
            if (track_pc && was_en) pc = pc + 32'd4;
        end
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_en", 32'(cpu_clk_en), 32'd0);
        chk("rst_remaining", 32'(remaining), 32'd0);
        chk("rst_steps", steps, 32'd0);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        rst_n = 1'b1;
        cyc(3);

        // Single step, then a held button gives no further pulse
        step_btn = 1'b1;
        cyc(1);
        chk("step_state", 32'(state), 32'd1);
        chk("step_en", 32'(cpu_clk_en), 32'd1);
        chk("step_steps", steps, 32'd1);
        cyc(1);
        chk("step_back_halt", 32'(state), 32'd0);
        chk("step_en_off", 32'(cpu_clk_en), 32'd0);
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            pulses += int'(cpu_clk_en);
        end
        chk("step_held_pulses", 32'(pulses), 32'd0);
        step_btn = 1'b0;
        cyc(1);

        // Free run at rate_div=3: pulse every 4th cycle after entry
        rate_div = 24'd3;
        run_btn  = 1'b1;
        cyc(1);
        chk("run_enter", 32'(state), 32'd2);
        run_btn = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            cyc(1);
            chk($sformatf("run_div3_en_k%0d", k), 32'(cpu_clk_en), (k % 4 == 0) ? 32'd1 : 32'd0);
        end
        // Stop edge lands in the tick cycle: the tick is suppressed
        run_btn = 1'b1;
        cyc(1);
        chk("run_stop_state", 32'(state), 32'd0);
        chk("run_stop_en", 32'(cpu_clk_en), 32'd0);
        run_btn = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            pulses += int'(cpu_clk_en);
        end
        chk("run_after_stop_pulses", 32'(pulses), 32'd0);
        chk("run_steps", steps, 32'd5);

        // Run-N of 5 at full rate
        rate_div  = 24'd0;
        run_count = 16'd5;
        runn_btn  = 1'b1;
        cyc(1);
        chk("runn_enter", 32'(state), 32'd3);
        chk("runn_rem0", 32'(remaining), 32'd5);
        chk("runn_en0", 32'(cpu_clk_en), 32'd0);
        runn_btn = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            chk($sformatf("runn_en_k%0d", k), 32'(cpu_clk_en), (k <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("runn_rem_k%0d", k), 32'(remaining), (k <= 5) ? 32'(5 - k) : 32'd0);
            chk($sformatf("runn_state_k%0d", k), 32'(state), (k < 5) ? 32'd3 : 32'd0);
        end
        chk("runn_steps", steps, 32'd10);
        run_count = 16'd0;
        runn_btn  = 1'b1;
        cyc(1);
        chk("runn_zero_state", 32'(state), 32'd0);
        runn_btn = 1'b0;
        cyc(5);
        chk("runn_zero_steps", steps, 32'd10);

        // Breakpoint at 0x0C: pulses at pc 0,4,8 then halt
        rate_div = 24'd1;
        pc       = 32'd0;
        track_pc = 1'b1;
        bp_en    = 1'b1;
        bp_addr  = 32'h0000_000C;
        run_btn  = 1'b1;
        cyc(1);
        run_btn = 1'b0;
        pulses  = 0;
        halt_k  = -1;
        for (int k = 1; k <= 40 && halt_k < 0; k++) begin
            cyc(1);
            pulses += int'(cpu_clk_en);
            if (state == 2'd0) halt_k = k;
        end
        chk("bp_halt_cycle", 32'(halt_k), 32'd8);
        chk("bp_pulses", 32'(pulses), 32'd3);
        chk("bp_hit_set", 32'(bp_hit), 32'd1);
        chk("bp_pc", pc, 32'h0000_000C);
        chk("bp_steps", steps, 32'd13);
        // Resume from the breakpoint PC
        run_btn = 1'b1;
        cyc(1);
        chk("bp_resume_state", 32'(state), 32'd2);
        chk("bp_hit_clear", 32'(bp_hit), 32'd0);
        run_btn = 1'b0;
        cyc(10);
        chk("bp_resume_running", 32'(state), 32'd2);
        chk("bp_resume_pc", pc, 32'h0000_001C);
        chk("bp_resume_steps", steps, 32'd18);
        run_btn = 1'b1;
        cyc(1);
        chk("bp_stop_state", 32'(state), 32'd0);
        run_btn  = 1'b0;
        bp_en    = 1'b0;
        track_pc = 1'b0;
        cyc(2);

        // run and step rising together: run wins, no step pulse
        rate_div = 24'd0;
        run_btn  = 1'b1;
        step_btn = 1'b1;
        cyc(1);
        chk("prio_state", 32'(state), 32'd2);
        chk("prio_en", 32'(cpu_clk_en), 32'd0);
        cyc(1);
        chk("prio_run_pulse", 32'(cpu_clk_en), 32'd1);
        run_btn  = 1'b0;
        step_btn = 1'b0;
        cyc(1);
        run_btn = 1'b1;
        cyc(1);
        chk("prio_stop_state", 32'(state), 32'd0);
        chk("prio_stop_en", 32'(cpu_clk_en), 32'd0);
        chk("prio_steps", steps, 32'd20);
        run_btn = 1'b0;
        cyc(2);

        // Reset during run-N with remaining=3; runn_btn held through reset
        run_count = 16'd5;
        runn_btn  = 1'b1;
        cyc(3);
        chk("rstrun_rem3", 32'(remaining), 32'd3);
        rst_n = 1'b0;
        cyc(1);
        chk("rstrun_state", 32'(state), 32'd0);
        chk("rstrun_en", 32'(cpu_clk_en), 32'd0);
        chk("rstrun_rem", 32'(remaining), 32'd0);
        chk("rstrun_steps", steps, 32'd0);
        cyc(1);
        chk("rstrun_hold_en", 32'(cpu_clk_en), 32'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("rstrel_state", 32'(state), 32'd3);
        chk("rstrel_rem", 32'(remaining), 32'd5);
        runn_btn = 1'b0;
        cyc(6);
        chk("rstrel_done_state", 32'(state), 32'd0);
        chk("rstrel_steps", steps, 32'd5);

        // Lowering rate_div mid-run ticks on the next cycle
        rate_div = 24'd8;
        run_btn  = 1'b1;
        cyc(1);
        run_btn = 1'b0;
        cyc(5);
        chk("lower_pre_en", 32'(cpu_clk_en), 32'd0);
        rate_div = 24'd2;
        cyc(1);
        chk("lower_en", 32'(cpu_clk_en), 32'd1);
        chk("lower_steps", steps, 32'd6);
        run_btn = 1'b1;
        cyc(1);
        chk("lower_stop_state", 32'(state), 32'd0);
        run_btn = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 24, width of the run-rate divider.
REQ-002 SHALL have parameter CNT_W, default 16, width of the run-N count.
REQ-003 SHALL have port clk_50M  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port step_btn  input  1  debounced level; each rising edge requests one step.
REQ-006 SHALL have port run_btn  input  1  debounced level; each rising edge toggles free-run/halt.
REQ-007 SHALL have port runn_btn  input  1  debounced level; each rising edge starts a run of run_count steps.
REQ-008 SHALL have port run_count  input  CNT_W  number of steps for run-N, sampled on the accepted runn_btn edge.
REQ-009 SHALL have port rate_div  input  DIV_W  run period minus one, in clk_50M cycles; sampled every cycle.
REQ-010 SHALL have port bp_en  input  1  breakpoint enable.
REQ-011 SHALL have port bp_addr  input  32  breakpoint PC.
REQ-012 SHALL have port pc  input  32  current CPU ProgramCounter.
REQ-013 SHALL have port cpu_clk_en  output  1  one-cycle CPU advance strobe, registered.
REQ-014 SHALL have port state  output  2  FSM state: 0 HALT, 1 STEP, 2 RUN, 3 RUNN.
REQ-015 SHALL have port remaining  output  CNT_W  steps left in RUNN; 0 otherwise.
REQ-016 SHALL have port steps  output  32  total cpu_clk_en pulses issued since reset.
REQ-017 SHALL have port bp_hit  output  1  sticky flag, breakpoint stopped a run.

Function
REQ-018 SHALL detect rising edges per button as btn & ~btn_q, btn_q being the input registered one cycle earlier.
REQ-019 In HALT, SHALL accept at most one edge per cycle, priority run_btn > runn_btn > step_btn; the others are discarded.
REQ-020 HALT + step edge in cycle t: state=STEP in t+1, cpu_clk_en=1 in t+1 only, state=HALT in t+2.
REQ-021 HALT + run edge: go RUN, div_cnt cleared to 0.
REQ-022 HALT + runn edge with run_count!=0: go RUNN, remaining<=run_count, div_cnt<=0; with run_count==0: stay HALT, edge ignored.
REQ-023 In RUN/RUNN, div_cnt SHALL increment each cycle; tick when div_cnt>=rate_div, then div_cnt<=0 (>= covers rate_div lowered mid-run; rate_div=0 ticks every cycle).
REQ-024 A tick SHALL set cpu_clk_en=1 in the following cycle, one cycle wide; first pulse after entry is rate_div+2 cycles after the edge.
REQ-025 In RUNN, each pulse SHALL decrement remaining; the pulse taken at remaining==1 returns state to HALT with remaining=0 in the same cycle.
REQ-026 A run_btn edge in RUN or RUNN SHALL go HALT next cycle and suppress any tick in that cycle; remaining<=0.
REQ-027 step_btn and runn_btn edges in STEP/RUN/RUNN SHALL be ignored.
REQ-028 Breakpoint: on a tick in RUN/RUNN with bp_en=1 and pc==bp_addr, SHALL go HALT, set bp_hit=1, issue no pulse.
REQ-029 Breakpoint SHALL be ignored for the first tick after entering RUN/RUNN, so a run may resume from the breakpoint PC.
REQ-030 STEP SHALL ignore breakpoints.
REQ-031 bp_hit SHALL clear on any accepted edge in HALT.
REQ-032 steps SHALL increment on every cpu_clk_en pulse and wrap from 2^32-1 to 0.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force: state=HALT, cpu_clk_en=0, remaining=0, steps=0, bp_hit=0, div_cnt=0, all btn_q=0, first-tick flag cleared.
REQ-034 Reset mid-RUN/RUNN SHALL abort with no further pulse; a button held high through reset produces one edge on the first cycle after release.

Verification
REQ-035 step_btn 0->1 at cycle 10 -> cpu_clk_en=1 at cycle 11 only, steps=1, state HALT at 12; held high 100 cycles -> no second pulse.
REQ-036 rate_div=3, run edge -> pulses every 4 cycles; run edge again -> HALT, no pulse thereafter, steps = pulse count.
REQ-037 run_count=5, rate_div=0, runn edge -> exactly 5 consecutive pulses, remaining 5..0, HALT after last; run_count=0 -> nothing.
REQ-038 bp_en=1, bp_addr=0x0C, model pc+=4 per pulse from 0 -> pulses at pc 0,4,8, HALT, bp_hit=1; run edge -> resumes past 0x0C, bp_hit=0.
REQ-039 run_btn and step_btn rise same cycle in HALT -> RUN entered, no STEP pulse.
REQ-040 rst_n=0 during RUNN remaining=3 -> next cycle all outputs at reset values; steps=0xFFFFFFFF + one pulse -> steps=0.
